// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - ISA constants, control word type and opcode decoder for the ID stage
// Purpose: opcode/funct encodings, ALU control encodings, instruction field positions, and the
//          combinational control decoder shared by decode_stage (and, later, the EX-stage ALU).
// Ports:   none (package)
package decode_stage_pkg;

  // Instruction field positions
  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int IMM_W     = 16;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    DST_NONE = 2'b00,
    DST_RD   = 2'b01,
    DST_RT   = 2'b10
  } dst_sel_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     ctrl_op2;
    alu_op_e  alu;
    logic     rt_used;
    dst_sel_e dst_sel;
  } ctrl_t;

  // Anything not recognised decodes to an all-zero control word (NOP).
  // rt_used follows the opcode alone, so an R-type with an unknown funct
  // still counts as reading rt for hazard purposes.
  function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[31:OPC_LSB])
      OP_RTYPE: begin
        c.rt_used = 1'b1;
        case (instr[5:0])
          FN_ADD:  begin c.reg_write = 1'b1; c.alu = ALU_ADD; end
          FN_SUB:  begin c.reg_write = 1'b1; c.alu = ALU_SUB; end
          FN_AND:  begin c.reg_write = 1'b1; c.alu = ALU_AND; end
          FN_OR:   begin c.reg_write = 1'b1; c.alu = ALU_OR;  end
          default: ;
        endcase
        if (c.reg_write) c.dst_sel = DST_RD;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.ctrl_op2  = 1'b1;
        c.dst_sel   = DST_RT;
      end
      OP_LW: begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.ctrl_op2  = 1'b1;
        c.dst_sel   = DST_RT;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.ctrl_op2  = 1'b1;
        c.rt_used   = 1'b1;
      end
      OP_BEQ: begin
        c.branch  = 1'b1;
        c.alu     = ALU_SUB;
        c.rt_used = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// rtl/decode_stage_reg_file.sv - 2R/1W register file with write-to-read bypass and sync reset
// Purpose: register storage for the ID stage; register 0 is hardwired to zero.
// Ports:   clk, reset (sync, active-high, clears all registers)
//          wr_en, wr_addr, wr_data         - write port, ignored during reset
//          rd_addr1/rd_data1, rd_addr2/rd_data2 - combinational read ports with bypass
module decode_stage_reg_file #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int NUM_REGS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [RADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [RADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0]  rd_data1,
  input  logic [RADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0]  rd_data2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_live;

  // A write to r0 is dropped entirely, so it can neither store nor bypass.
  assign wr_live = wr_en && !reset && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (rd_addr1 == '0)                       rd_data1 = '0;
    else if (wr_live && wr_addr == rd_addr1)  rd_data1 = wr_data;
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (rd_addr2 == '0)                       rd_data2 = '0;
    else if (wr_live && wr_addr == rd_addr2)  rd_data2 = wr_data;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage with load-use hazard detection and ID/EX register
// Purpose: decodes instr, reads the register file, sign-extends the immediate and registers the
//          operands and control word for EX; stalls fetch on load-use and squashes on flush.
// Ports:   clk, reset (sync, active-high)
//          instr, instrValid, flush                   - from IF/ID and EX
//          wbRegWrite, wbReg, wbData                  - writeback port
//          readData1, readData2, address, ctrlOp2, aluCtrl, memRead, memWrite, branch,
//          regWrite, destReg, exValid                 - registered ID/EX outputs
//          stallFetch                                 - combinational fetch hold
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int NUM_REGS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               instrValid,
  input  logic               flush,
  input  logic               wbRegWrite,
  input  logic [RADDR_W-1:0] wbReg,
  input  logic [DATA_W-1:0]  wbData,
  output logic [DATA_W-1:0]  readData1,
  output logic [DATA_W-1:0]  readData2,
  output logic [DATA_W-1:0]  address,
  output logic               ctrlOp2,
  output logic [1:0]         aluCtrl,
  output logic               memRead,
  output logic               memWrite,
  output logic               branch,
  output logic               regWrite,
  output logic [RADDR_W-1:0] destReg,
  output logic               exValid,
  output logic               stallFetch
);

  logic [RADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0]  rs_data, rt_data, imm_ext;
  logic [RADDR_W-1:0] dec_dest;
  ctrl_t              dec;
  logic               hazard;
  logic               load_bubble;

  assign rs = instr[RS_LSB +: RADDR_W];
  assign rt = instr[RT_LSB +: RADDR_W];
  assign rd = instr[RD_LSB +: RADDR_W];

  assign imm_ext = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
  assign dec     = decode_ctrl(instr);

  always_comb begin
    dec_dest = '0;
    case (dec.dst_sel)
      DST_RD:  dec_dest = rd;
      DST_RT:  dec_dest = rt;
      default: dec_dest = '0;
    endcase
  end

  decode_stage_reg_file #(
    .DATA_W   (DATA_W),
    .RADDR_W  (RADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wbRegWrite),
    .wr_addr  (wbReg),
    .wr_data  (wbData),
    .rd_addr1 (rs),
    .rd_data1 (rs_data),
    .rd_addr2 (rt),
    .rd_data2 (rt_data)
  );

  // Load in EX whose result is needed by the instruction in ID.
  assign hazard = exValid && memRead && (destReg != '0) && instrValid &&
                  ((destReg == rs) || (dec.rt_used && (destReg == rt)));

  // A flush kills the waiting instruction, so there is nothing to hold.
  assign stallFetch  = hazard && !flush && !reset;
  assign load_bubble = flush || hazard || !instrValid;

  always_ff @(posedge clk) begin
    if (reset || load_bubble) begin
      readData1 <= '0;
      readData2 <= '0;
      address   <= '0;
      ctrlOp2   <= 1'b0;
      aluCtrl   <= ALU_ADD;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      branch    <= 1'b0;
      regWrite  <= 1'b0;
      destReg   <= '0;
      exValid   <= 1'b0;
    end else begin
      readData1 <= rs_data;
      readData2 <= rt_data;
      address   <= imm_ext;
      ctrlOp2   <= dec.ctrl_op2;
      aluCtrl   <= dec.alu;
      memRead   <= dec.mem_read;
      memWrite  <= dec.mem_write;
      branch    <= dec.branch;
      regWrite  <= dec.reg_write;
      destReg   <= dec_dest;
      exValid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized and directed self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instrValid;
  logic        flush;
  logic        wbRegWrite;
  logic [4:0]  wbReg;
  logic [31:0] wbData;
  logic [31:0] readData1, readData2, address;
  logic        ctrlOp2;
  logic [1:0]  aluCtrl;
  logic        memRead, memWrite, branch, regWrite;
  logic [4:0]  destReg;
  logic        exValid;
  logic        stallFetch;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .instrValid (instrValid),
    .flush      (flush),
    .wbRegWrite (wbRegWrite),
    .wbReg      (wbReg),
    .wbData     (wbData),
    .readData1  (readData1),
    .readData2  (readData2),
    .address    (address),
    .ctrlOp2    (ctrlOp2),
    .aluCtrl    (aluCtrl),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .branch     (branch),
    .regWrite   (regWrite),
    .destReg    (destReg),
    .exValid    (exValid),
    .stallFetch (stallFetch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state: architectural registers and the expected ID/EX contents
  logic [31:0] m_regs [32];
  logic [31:0] e_rd1, e_rd2, e_addr;
  logic        e_op2, e_mr, e_mw, e_br, e_rw, e_ev, e_zero;
  logic [1:0]  e_alu;
  logic [4:0]  e_dst;
  bit          last_stall;

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
    logic [4:0] d, s, t;
    d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
    return {6'd0, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
    logic [4:0] s, t;
    s = rs[4:0]; t = rt[4:0];
    return {op, s, t, imm};
  endfunction

  // Instruction meaning taken straight from the ISA table: what it writes, where, and what it reads.
  task automatic model_decode(input logic [31:0] ins,
                              output logic rw, output logic mr, output logic mw, output logic br,
                              output logic op2, output logic [1:0] alu, output logic [4:0] dst,
                              output logic rt_used);
    int opc, fn;
    opc = int'(ins[31:26]);
    fn  = int'(ins[5:0]);
    rw = 0; mr = 0; mw = 0; br = 0; op2 = 0; alu = 2'd0; dst = 5'd0; rt_used = 0;
    if (opc == 0) begin
      rt_used = 1;
      if (fn == 32 || fn == 34 || fn == 36 || fn == 37) begin
        rw  = 1;
        dst = ins[15:11];
        alu = (fn == 32) ? 2'd0 : (fn == 34) ? 2'd1 : (fn == 36) ? 2'd2 : 2'd3;
      end
    end else if (opc == 8)  begin rw = 1; op2 = 1; dst = ins[20:16]; end
    else if (opc == 35)     begin rw = 1; op2 = 1; mr = 1; dst = ins[20:16]; end
    else if (opc == 43)     begin op2 = 1; mw = 1; rt_used = 1; end
    else if (opc == 4)      begin br = 1; alu = 2'd1; rt_used = 1; end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wbRegWrite && wbReg == r) return wbData;
    return m_regs[r];
  endfunction

  task automatic compare_all();
    chk("exValid",  exValid,  e_ev);
    chk("regWrite", regWrite, e_rw);
    chk("memRead",  memRead,  e_mr);
    chk("memWrite", memWrite, e_mw);
    chk("branch",   branch,   e_br);
    if (e_ev || e_zero) begin
      chk("ctrlOp2",   ctrlOp2,   e_op2);
      chk("aluCtrl",   aluCtrl,   e_alu);
      chk("destReg",   destReg,   e_dst);
      chk("readData1", readData1, e_rd1);
      chk("readData2", readData2, e_rd2);
      chk("address",   address,   e_addr);
    end
  endtask

  // One clock: check stallFetch mid-cycle, advance the model at the edge, compare after it.
  task automatic step();
    logic rw, mr, mw, br, op2, rtu;
    logic [1:0]  alu;
    logic [4:0]  dst, rs, rt;
    logic [31:0] a, b;
    bit hz, stall;
    @(negedge clk);
    model_decode(instr, rw, mr, mw, br, op2, alu, dst, rtu);
    rs = instr[25:21];
    rt = instr[20:16];
    hz = !reset && e_ev && e_mr && e_dst != 0 && instrValid && (e_dst == rs || (rtu && e_dst == rt));
    stall = hz && !flush;
    chk("stallFetch", stallFetch, stall);
    a = model_read(rs);
    b = model_read(rt);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else if (wbRegWrite && wbReg != 0) begin
      m_regs[wbReg] = wbData;
    end
    if (reset || flush || hz || !instrValid) begin
      e_ev = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_br = 0;
      e_op2 = 0; e_alu = 0; e_dst = 0; e_rd1 = 0; e_rd2 = 0; e_addr = 0;
      e_zero = reset;
    end else begin
      e_ev = 1; e_rw = rw; e_mr = mr; e_mw = mw; e_br = br;
      e_op2 = op2; e_alu = alu; e_dst = dst; e_rd1 = a; e_rd2 = b;
      e_addr = {{16{instr[15]}}, instr[15:0]};
      e_zero = 0;
    end
    last_stall = stall;
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    reset = 0; instrValid = 0; flush = 0; wbRegWrite = 0; wbReg = 0; wbData = 0; instr = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    int k, rd, rs, rt;
    logic [15:0] imm;
    k  = $urandom_range(0, 9);
    rd = $urandom_range(0, 7);
    rs = $urandom_range(0, 7);
    rt = $urandom_range(0, 7);
    imm = 16'($urandom);
    case (k)
      0: return enc_r(6'b100000, rd, rs, rt);
      1: return enc_r(6'b100010, rd, rs, rt);
      2: return enc_r(6'b100100, rd, rs, rt);
      3: return enc_r(6'b100101, rd, rs, rt);
      4: return enc_i(6'b001000, rt, rs, imm);
      5: return enc_i(6'b100011, rt, rs, imm);
      6: return enc_i(6'b101011, rt, rs, imm);
      7: return enc_i(6'b000100, rt, rs, imm);
      8: return enc_i(6'b111111, rt, rs, imm);
      default: return enc_r(6'b000111, rd, rs, rt);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    e_rd1 = 0; e_rd2 = 0; e_addr = 0; e_op2 = 0; e_mr = 0; e_mw = 0; e_br = 0;
    e_rw = 0; e_ev = 0; e_alu = 0; e_dst = 0; e_zero = 1; last_stall = 0;

    // Reset for two cycles, with writeback traffic that must be ignored
    idle_inputs();
    reset = 1; wbRegWrite = 1; wbReg = 5; wbData = 32'h5555_5555;
    instr = enc_r(6'b100000, 1, 2, 3); instrValid = 1;
    step();
    step();
    chk("reset_exValid", exValid, 0);
    chk("reset_readData1", readData1, 0);
    idle_inputs();
    instr = enc_r(6'b100000, 1, 5, 5); instrValid = 1;
    step();
    chk("r5_after_reset", readData1, 32'd0);

    // Writeback r3=7 then add r4,r3,r3
    idle_inputs();
    wbRegWrite = 1; wbReg = 3; wbData = 32'h7;
    step();
    idle_inputs();
    instr = enc_r(6'b100000, 4, 3, 3); instrValid = 1;
    step();
    chk("add_rd1", readData1, 32'h7);
    chk("add_rd2", readData2, 32'h7);
    chk("add_alu", aluCtrl, 2'b00);
    chk("add_dest", destReg, 5'd4);
    chk("add_regWrite", regWrite, 1);

    // lw r2,-4(r1) followed by a dependent add: one stall, one bubble
    instr = enc_i(6'b100011, 2, 1, 16'hFFFC);
    step();
    chk("lw_address", address, 32'hFFFF_FFFC);
    chk("lw_memRead", memRead, 1);
    chk("lw_dest", destReg, 5'd2);
    instr = enc_r(6'b100000, 5, 2, 6);
    step();
    chk("loaduse_stalled", last_stall, 1);
    chk("loaduse_bubble", exValid, 0);
    step();
    chk("loaduse_issue", exValid, 1);
    chk("loaduse_dest", destReg, 5'd5);

    // Bypass: or r8,r7,r0 while r7 is being written back
    idle_inputs();
    instr = enc_r(6'b100101, 8, 7, 0); instrValid = 1;
    wbRegWrite = 1; wbReg = 7; wbData = 32'hDEAD_BEEF;
    step();
    chk("bypass_rd1", readData1, 32'hDEAD_BEEF);
    chk("bypass_rd2", readData2, 32'd0);
    chk("bypass_alu", aluCtrl, 2'b11);

    // beq with flush, then flush during a load-use stall
    idle_inputs();
    instr = enc_i(6'b000100, 2, 1, 16'h0010); instrValid = 1; flush = 1;
    step();
    chk("flush_branch", branch, 0);
    flush = 0;
    instr = enc_i(6'b100011, 2, 1, 16'h0000);
    step();
    instr = enc_r(6'b100000, 5, 2, 6); flush = 1;
    step();
    chk("flush_stall", last_stall, 0);
    chk("flush_bubble", exValid, 0);

    // Write to r0 is discarded; unknown opcode is a valid NOP
    idle_inputs();
    wbRegWrite = 1; wbReg = 0; wbData = 32'h1234;
    step();
    idle_inputs();
    instr = enc_r(6'b100000, 1, 0, 0); instrValid = 1;
    step();
    chk("r0_zero", readData1, 32'd0);
    instr = 32'hFC00_0000;
    step();
    chk("nop_exValid", exValid, 1);
    chk("nop_regWrite", regWrite, 0);

    // Randomized traffic; a stalled instruction is held in ID as fetch would
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 63) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      instrValid = ($urandom_range(0, 7) != 0);
      wbRegWrite = ($urandom_range(0, 1) == 1);
      wbReg      = 5'($urandom_range(0, 7));
      wbData     = $urandom;
      if (!last_stall) instr = rand_instr();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
